// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: state encoding and default counter width.
// Optional watchdog is enabled by defining CAPTURE_TIMEOUT_EN.
package capture_pkg;

  localparam int CNT_WIDTH_DEF = 32;
  localparam int TMO_WIDTH     = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POSTTRIG = 3'd3,
    ST_DONE     = 3'd4
  } cap_state_t;

  function automatic logic is_running(input cap_state_t s);
    return (s == ST_FILL) || (s == ST_ARMED) || (s == ST_POSTTRIG);
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// Host/trigger/generator signal bundle for the capture sequencer.
// timeoutCycles/timedOut exist only when CAPTURE_TIMEOUT_EN is defined.
interface capture_sequencer_if #(
  parameter int CNT_WIDTH = capture_pkg::CNT_WIDTH_DEF
);
  logic                 start;
  logic                 abort;
  logic                 clear;
  logic                 trigger_in;
  logic                 sample_we;
  logic                 complete;
  logic [CNT_WIDTH-1:0] preTriggerSampleCountMax;
`ifdef CAPTURE_TIMEOUT_EN
  logic [capture_pkg::TMO_WIDTH-1:0] timeoutCycles;
  logic                 timedOut;
`endif
  logic                 idle;
  logic                 preTrigger;
  logic                 postTrigger;
  logic                 triggered;
  logic                 abort_out;
  logic                 captureDone;
  logic                 aborted;
  logic [2:0]           state;

  modport master (
    output start, abort, clear, trigger_in, sample_we, complete, preTriggerSampleCountMax,
`ifdef CAPTURE_TIMEOUT_EN
    output timeoutCycles,
    input  timedOut,
`endif
    input  idle, preTrigger, postTrigger, triggered, abort_out, captureDone, aborted, state
  );

  modport slave (
    input  start, abort, clear, trigger_in, sample_we, complete, preTriggerSampleCountMax,
`ifdef CAPTURE_TIMEOUT_EN
    input  timeoutCycles,
    output timedOut,
`endif
    output idle, preTrigger, postTrigger, triggered, abort_out, captureDone, aborted, state
  );

endinterface

// File: rtl/capture_watchdog.sv
// ARMED-state watchdog: down-counter reloaded while disarmed, expires on the
// timeoutCycles-th armed cycle. Used only when CAPTURE_TIMEOUT_EN is defined.
module capture_watchdog
  import capture_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 armed,
  input  logic [TMO_WIDTH-1:0] load_value,
  output logic                 expired
);

  logic [TMO_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!armed) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // cnt holds load_value on the first armed cycle, so reaching 1 marks cycle N
  assign expired = armed && (load_value != '0) && (cnt == {{(TMO_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/capture_sequencer.sv
// Capture state machine driving the sample generator's mode inputs.
// Define CAPTURE_TIMEOUT_EN to add the ARMED-state watchdog (timeoutCycles/timedOut).
//
// state    | meaning
// IDLE     | waiting for host start
// FILL     | collecting pre-trigger packets until count == max
// ARMED    | waiting for trigger_in (or watchdog expiry)
// POSTTRIG | waiting for generator completion strobe
// DONE     | capture finished; held until clear or restart
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  capture_sequencer_if.slave bus
);

  cap_state_t           state;
  cap_state_t           nxt;
  logic [CNT_WIDTH-1:0] fill_cnt;
  logic                 running;
  logic                 armed;
  logic                 tmo_hit;
  logic                 fire;

  assign running = is_running(state);
  assign armed   = (state == ST_ARMED);

`ifdef CAPTURE_TIMEOUT_EN
  capture_watchdog u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .armed      (armed),
    .load_value (bus.timeoutCycles),
    .expired    (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  assign fire          = bus.trigger_in | tmo_hit;
  assign bus.triggered = armed & fire & ~bus.abort;
  assign bus.abort_out = bus.abort & running;
  assign bus.state     = state;

  // abort outranks every other event in a running state
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:     if (bus.start) nxt = ST_FILL;
      ST_FILL: begin
        if (bus.abort)                                   nxt = ST_DONE;
        else if (fill_cnt == bus.preTriggerSampleCountMax) nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (bus.abort)  nxt = ST_DONE;
        else if (fire)  nxt = ST_POSTTRIG;
      end
      ST_POSTTRIG: begin
        if (bus.abort)         nxt = ST_DONE;
        else if (bus.complete) nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start)      nxt = ST_FILL;
        else if (bus.clear) nxt = ST_IDLE;
      end
      default:     nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      fill_cnt        <= '0;
      bus.aborted     <= 1'b0;
      bus.idle        <= 1'b1;
      bus.preTrigger  <= 1'b0;
      bus.postTrigger <= 1'b0;
      bus.captureDone <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      bus.timedOut    <= 1'b0;
`endif
    end else begin
      state           <= nxt;
      bus.idle        <= (nxt == ST_IDLE);
      bus.preTrigger  <= (nxt == ST_FILL) || (nxt == ST_ARMED);
      bus.postTrigger <= (nxt == ST_POSTTRIG);
      bus.captureDone <= (nxt == ST_DONE);

      if (!running && nxt == ST_FILL) begin
        fill_cnt    <= '0;
        bus.aborted <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
        bus.timedOut <= 1'b0;
`endif
      end else begin
        if (state == ST_FILL && bus.sample_we && fill_cnt != '1)
          fill_cnt <= fill_cnt + 1'b1;
        if (running && bus.abort)
          bus.aborted <= 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
        // a genuine trigger on the expiry cycle is not reported as a timeout
        if (armed && tmo_hit && !bus.trigger_in && !bus.abort)
          bus.timedOut <= 1'b1;
`endif
      end
    end
  end

endmodule
